// File: rtl/mlkem_pkg.sv
// rtl/mlkem_pkg.sv - shared ML-KEM constants and sampler state type
package mlkem_pkg;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rs_state_t;

endpackage

// File: rtl/byte_shift_buf.sv
// rtl/byte_shift_buf.sv - 16-byte shift buffer with append-8 and pop-3
module byte_shift_buf (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr,
    input  logic        push,
    input  logic [63:0] push_data,
    input  logic        pop,
    output logic [23:0] head,
    output logic [4:0]  cnt
);

    // Byte i lives at data_q[8*i +: 8]; bytes at or above cnt are kept zero
    // so an append can simply be OR-ed in behind the surviving bytes.
    logic [127:0] data_q;
    logic [127:0] data_d;
    logic [4:0]   base;
    logic [4:0]   cnt_d;

    // Pop first, then append the new word right after whatever remains.
    always_comb begin
        base   = pop ? (cnt - 5'd3) : cnt;
        data_d = pop ? (data_q >> 24) : data_q;
        cnt_d  = base;
        if (push) begin
            data_d = data_d | ({64'd0, push_data} << {base, 3'b000});
            cnt_d  = base + 5'd8;
        end
        if (clr) begin
            data_d = '0;
            cnt_d  = '0;
        end
    end

    // Buffer and count registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= '0;
            cnt    <= '0;
        end else begin
            data_q <= data_d;
            cnt    <= cnt_d;
        end
    end

    assign head = data_q[23:0];

endmodule

// File: rtl/rej_sample_ntt.sv
// rtl/rej_sample_ntt.sv - SHAKE128 rejection sampler producing NTT-domain coefficients
module rej_sample_ntt
    import mlkem_pkg::*;
#(
    parameter int Q     = KYBER_Q,
    parameter int NCOEF = KYBER_N
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [63:0] word_in,
    input  logic        word_val,
    output logic        word_en,
    output logic [11:0] coef_out,
    output logic [7:0]  coef_idx,
    output logic        coef_val,
    input  logic        coef_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [11:0] QB       = 12'(Q);
    localparam logic [7:0]  LAST_IDX = 8'(NCOEF - 1);

    rs_state_t   state;
    rs_state_t   state_nxt;
    logic        clr;
    logic        push;
    logic        pop;
    logic [23:0] head;
    logic [4:0]  bcnt;
    logic [11:0] d1;
    logic [11:0] d2;
    logic        d1_ok;
    logic        d2_ok;
    logic        hs;
    logic        last_hs;
    logic        slot_open;
    logic        take_pend;
    logic        load;
    logic [11:0] load_val;
    logic [11:0] d2_pend;
    logic        d2_v;

    byte_shift_buf u_buf (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .push      (push),
        .push_data (word_in),
        .pop       (pop),
        .head      (head),
        .cnt       (bcnt)
    );

    // Run control: start launches a run, the final handshake ends it.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        clr       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    clr       = 1'b1;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_hs) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Word intake, candidate split/compare and output-slot arbitration.
    // The slot is closed on the final handshake so no 257th value slips in.
    always_comb begin
        word_en   = (state == RUN) && (bcnt <= 5'd8);
        push      = word_en && word_val;
        hs        = coef_val && coef_ready;
        last_hs   = hs && (coef_idx == LAST_IDX);
        slot_open = (state == RUN) && (!coef_val || coef_ready) && !last_hs;
        take_pend = slot_open && d2_v;
        pop       = slot_open && !d2_v && (bcnt >= 5'd3);
        d1        = {head[11:8], head[7:0]};
        d2        = {head[23:16], head[15:12]};
        d1_ok     = d1 < QB;
        d2_ok     = d2 < QB;
        load      = take_pend || (pop && (d1_ok || d2_ok));
        load_val  = take_pend ? d2_pend : (d1_ok ? d1 : d2);
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Output slot, index counter and the pending second candidate.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            coef_out <= '0;
            coef_idx <= '0;
            coef_val <= 1'b0;
            d2_pend  <= '0;
            d2_v     <= 1'b0;
        end else if (clr) begin
            coef_idx <= '0;
            coef_val <= 1'b0;
            d2_v     <= 1'b0;
        end else begin
            if (hs) coef_idx <= coef_idx + 8'd1;
            if (load) begin
                coef_val <= 1'b1;
                coef_out <= load_val;
            end else if (hs) begin
                coef_val <= 1'b0;
            end
            if (take_pend) begin
                d2_v <= 1'b0;
            end else if (pop && d1_ok && d2_ok) begin
                d2_v    <= 1'b1;
                d2_pend <= d2;
            end
        end
    end

endmodule

// File: tb/tb_rej_sample_ntt.sv
// tb/tb_rej_sample_ntt.sv - scoreboard bench for the rejection sampler
module tb_rej_sample_ntt;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [63:0] word_in = '0;
    logic        word_val = 1'b0;
    logic        word_en;
    logic [11:0] coef_out;
    logic [7:0]  coef_idx;
    logic        coef_val;
    logic        coef_ready = 1'b1;
    logic        busy;
    logic        done;

    rej_sample_ntt dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .word_in    (word_in),
        .word_val   (word_val),
        .word_en    (word_en),
        .coef_out   (coef_out),
        .coef_idx   (coef_idx),
        .coef_val   (coef_val),
        .coef_ready (coef_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] coef;
        logic [7:0]  idx;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  feed_q[$];
    logic [7:0]  mdl_q[$];
    logic [11:0] got_coef[$];
    logic [7:0]  got_idx[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          model_cnt = 0;
    int          done_cnt = 0;
    bit          gap_en = 1'b0;
    bit          rdy_rand = 1'b0;
    bit          xfer = 1'b0;
    bit          held_v = 1'b0;
    logic [11:0] held_out = '0;
    logic [7:0]  held_idx = '0;
    logic [11:0] last_d1;

    // Word feeder, ready driver and output monitor, all on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                xfer     = 1'b0;
                held_v   = 1'b0;
                word_val = 1'b0;
            end else begin
                if (xfer && feed_q.size() >= 8)
                    for (int i = 0; i < 8; i++) void'(feed_q.pop_front());
                if (feed_q.size() >= 8 && (!gap_en || $urandom_range(0, 3) != 0)) begin
                    word_val = 1'b1;
                    for (int i = 0; i < 8; i++) word_in[8*i +: 8] = feed_q[i];
                end else begin
                    word_val = 1'b0;
                end
                xfer = word_val && word_en;
                coef_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (held_v) begin
                    n_checks++;
                    if (coef_val !== 1'b1 || coef_out !== held_out || coef_idx !== held_idx)
                        $display("FAIL hold: got val=%0b %0d@%0d want 1 %0d@%0d",
                                 coef_val, coef_out, coef_idx, held_out, held_idx);
                    else n_pass++;
                end
                held_v   = coef_val && !coef_ready;
                held_out = coef_out;
                held_idx = coef_idx;
                if (coef_val && coef_ready) begin
                    exp_t e;
                    got_coef.push_back(coef_out);
                    got_idx.push_back(coef_idx);
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL scoreboard: unexpected %0d@%0d, want nothing", coef_out, coef_idx);
                    end else begin
                        e = exp_q.pop_front();
                        if (coef_out !== e.coef || coef_idx !== e.idx)
                            $display("FAIL scoreboard: got %0d@%0d want %0d@%0d",
                                     coef_out, coef_idx, e.coef, e.idx);
                        else n_pass++;
                    end
                end
                if (done) done_cnt++;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Queue one stream byte and run the reference split/accept model per 3 bytes.
    task automatic push_byte(input logic [7:0] b);
        exp_t e;
        logic [11:0] c1;
        logic [11:0] c2;
        feed_q.push_back(b);
        mdl_q.push_back(b);
        if (mdl_q.size() == 3) begin
            c1 = {mdl_q[1][3:0], mdl_q[0]};
            c2 = {mdl_q[2], mdl_q[1][7:4]};
            mdl_q.delete();
            if (c1 < 12'd3329 && model_cnt < 256) begin
                e.coef = c1; e.idx = 8'(model_cnt); exp_q.push_back(e); model_cnt++;
            end
            if (c2 < 12'd3329 && model_cnt < 256) begin
                e.coef = c2; e.idx = 8'(model_cnt); exp_q.push_back(e); model_cnt++;
            end
        end
    endtask

    task automatic add_word(input logic [63:0] w);
        for (int i = 0; i < 8; i++) push_byte(w[8*i +: 8]);
    endtask

    task automatic add_pair(input logic [11:0] a, input logic [11:0] b);
        push_byte(a[7:0]);
        push_byte({b[3:0], a[11:8]});
        push_byte(b[11:4]);
    endtask

    task automatic pad_word();
        while (feed_q.size() % 8 != 0) push_byte(8'($urandom));
    endtask

    task automatic clear_bench();
        feed_q.delete(); exp_q.delete(); mdl_q.delete();
        got_coef.delete(); got_idx.delete();
        model_cnt = 0; done_cnt = 0;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int c = 0; c < budget && (feed_q.size() != 0 || exp_q.size() != 0); c++) tick(1);
        tick(6);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL drain: %0d coefficients still expected, want 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick(2);
        n_checks++;
        if ({word_en, coef_val, busy, done} !== 4'b0)
            $display("FAIL reset_ctrl: got en/val/busy/done=%b want 0000", {word_en, coef_val, busy, done});
        else n_pass++;
        n_checks++;
        if (coef_out !== 12'd0 || coef_idx !== 8'd0)
            $display("FAIL reset_data: got %0d@%0d want 0@0", coef_out, coef_idx);
        else n_pass++;
        rstn = 1'b1;
        tick(2);
        clear_bench();
        start_run();
        n_checks++;
        if (busy !== 1'b1 || word_en !== 1'b1)
            $display("FAIL start_latency: got busy=%b word_en=%b want 1 1", busy, word_en);
        else n_pass++;
    endtask

    task automatic test_full_reject();
        for (int i = 0; i < 3; i++) add_word(64'hFFFF_FFFF_FFFF_FFFF);
        wait_drain(200);
        n_checks++;
        if (got_coef.size() != 0 || coef_val !== 1'b0)
            $display("FAIL full_reject: got %0d outputs val=%b want 0 0", got_coef.size(), coef_val);
        else n_pass++;
        n_checks++;
        if (word_en !== 1'b1 || busy !== 1'b1)
            $display("FAIL reject_req: got word_en=%b busy=%b want 1 1", word_en, busy);
        else n_pass++;
    endtask

    task automatic test_valid_split();
        got_coef.delete(); got_idx.delete();
        add_word(64'h0000_0000_0003_0201);
        add_word(64'd0);
        add_word(64'd0);
        wait_drain(200);
        n_checks++;
        if (got_coef.size() < 2 || got_coef[0] !== 12'd513 || got_idx[0] !== 8'd0 ||
            got_coef[1] !== 12'd48 || got_idx[1] !== 8'd1)
            $display("FAIL valid_split: got %0d entries first %0d@%0d,%0d@%0d want 513@0,48@1",
                     got_coef.size(), got_coef[0], got_idx[0], got_coef[1], got_idx[1]);
        else n_pass++;
    endtask

    task automatic test_boundary();
        got_coef.delete(); got_idx.delete();
        push_byte(8'h00); push_byte(8'h1D); push_byte(8'hD0);
        add_pair(12'hFFF, 12'hFFF);
        push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
        for (int i = 0; i < 5; i++) add_pair(12'hFFF, 12'hFFF);
        wait_drain(200);
        n_checks++;
        if (got_coef.size() != 3 || got_coef[0] !== 12'd3328 || got_idx[0] !== 8'd16)
            $display("FAIL boundary: got %0d entries first %0d@%0d want 3 entries 3328@16",
                     got_coef.size(), got_coef[0], got_idx[0]);
        else n_pass++;
        n_checks++;
        if (got_coef[1] !== 12'd513 || got_idx[1] !== 8'd17)
            $display("FAIL boundary_next: got %0d@%0d want 513@17", got_coef[1], got_idx[1]);
        else n_pass++;
    endtask

    task automatic test_straddle_end();
        got_coef.delete(); got_idx.delete();
        done_cnt = 0;
        add_pair(12'hFFF, 12'hFFF);
        add_pair(12'hFFF, 12'hFFF);
        push_byte(8'h34); push_byte(8'h12); push_byte(8'h0B);
        for (int g = 0; g < 117; g++) begin
            if (g % 5 == 0) add_pair(12'hFFF, 12'hFFF);
            add_pair(12'($urandom_range(0, 3328)), 12'($urandom_range(0, 3328)));
        end
        last_d1 = 12'($urandom_range(0, 3328));
        add_pair(last_d1, 12'd3000);
        pad_word();
        add_word(64'd0);
        for (int c = 0; c < 3000 && done_cnt == 0; c++) tick(1);
        tick(2);
        n_checks++;
        if (got_coef.size() < 2 || got_coef[0] !== 12'd564 || got_idx[0] !== 8'd19 ||
            got_coef[1] !== 12'd177 || got_idx[1] !== 8'd20)
            $display("FAIL straddle: got %0d@%0d,%0d@%0d want 564@19,177@20",
                     got_coef[0], got_idx[0], got_coef[1], got_idx[1]);
        else n_pass++;
        n_checks++;
        if (done_cnt != 1) $display("FAIL done_pulse: got %0d pulses want 1", done_cnt);
        else n_pass++;
        n_checks++;
        if (got_coef.size() != 237 || got_coef[got_coef.size()-1] !== last_d1 ||
            got_idx[got_idx.size()-1] !== 8'd255)
            $display("FAIL last_coef: got %0d entries last %0d@%0d want 237 entries %0d@255",
                     got_coef.size(), got_coef[got_coef.size()-1], got_idx[got_idx.size()-1], last_d1);
        else n_pass++;
        n_checks++;
        if ({word_en, busy, coef_val} !== 3'b000)
            $display("FAIL end_idle: got en/busy/val=%b want 000", {word_en, busy, coef_val});
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int bad;
        clear_bench();
        gap_en = 1'b1;
        rdy_rand = 1'b1;
        start_run();
        while (model_cnt < 256) push_byte(8'($urandom));
        pad_word();
        add_word(64'd0);
        for (int c = 0; c < 20000 && done_cnt == 0; c++) tick(1);
        tick(3);
        n_checks++;
        if (done_cnt != 1 || got_coef.size() != 256)
            $display("FAIL backpressure: got %0d pulses %0d coefs want 1 256", done_cnt, got_coef.size());
        else n_pass++;
        bad = 0;
        for (int i = 0; i < got_idx.size(); i++) if (got_idx[i] !== 8'(i)) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL idx_seq: got %0d gaps want 0", bad);
        else n_pass++;
        gap_en = 1'b0;
        rdy_rand = 1'b0;
    endtask

    task automatic test_reset_mid();
        clear_bench();
        start_run();
        while (model_cnt < 256) push_byte(8'($urandom));
        pad_word();
        for (int c = 0; c < 3000 && got_idx.size() < 101; c++) tick(1);
        n_checks++;
        if (got_idx.size() < 101) $display("FAIL reach_100: got %0d coefs want 101", got_idx.size());
        else n_pass++;
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({word_en, coef_val, busy, done} !== 4'b0 || coef_out !== 12'd0 || coef_idx !== 8'd0)
            $display("FAIL mid_reset: got en/val/busy/done=%b %0d@%0d want 0000 0@0",
                     {word_en, coef_val, busy, done}, coef_out, coef_idx);
        else n_pass++;
        clear_bench();
        tick(2);
        rstn = 1'b1;
        tick(1);
        start_run();
        add_word(64'h0000_0000_0003_0201);
        add_word(64'd0);
        add_word(64'd0);
        wait_drain(200);
        n_checks++;
        if (got_coef.size() < 1 || got_coef[0] !== 12'd513 || got_idx[0] !== 8'd0)
            $display("FAIL restart: got %0d@%0d want 513@0", got_coef[0], got_idx[0]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_reject();
        test_valid_split();
        test_boundary();
        test_straddle_end();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
